modn_cascade_counter: RTL and testbench

Parametrised multi-stage modulo-N counter chain for the digital-clock datapath, e.g. sec/min/hour or digit chains. Each stage has its own run-time modulus. The chain counts up or down, supports parallel load with range checking, and emits per-stage carry/borrow plus a whole-chain wrap. It supersedes single-stage mod-N counters that were cascaded by hand at top level.

---
 rtl/modn_cascade_counter_if.sv | 25 ++
 rtl/modn_cascade_counter.sv | 82 ++++++++
 tb/tb_modn_cascade_counter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/modn_cascade_counter_if.sv
// rtl/modn_cascade_counter_if.sv - control, load and status bundle for the cascaded mod-N counter
interface modn_cascade_counter_if #(
    parameter int STAGES = 3,
    parameter int WIDTH  = 6
);
    logic                      EN;
    logic                      UP;
    logic                      LOAD;
    logic [STAGES*WIDTH-1:0]   Data;
    logic [STAGES*WIDTH-1:0]   Mode;
    logic [STAGES*WIDTH-1:0]   CNT;
    logic [STAGES-1:0]         Carry;
    logic                      Wrap;
    logic                      Err;

    modport master (
        output EN, UP, LOAD, Data, Mode,
        input  CNT, Carry, Wrap, Err
    );

    modport slave (
        input  EN, UP, LOAD, Data, Mode,
        output CNT, Carry, Wrap, Err
    );
endinterface

// File: rtl/modn_cascade_counter.sv
// rtl/modn_cascade_counter.sv - chain of run-time modulus up/down counters with load, carry and wrap
module modn_cascade_counter #(
    parameter int STAGES = 3,
    parameter int WIDTH  = 6
) (
    input  logic                     Clk,
    input  logic                     RST,
    modn_cascade_counter_if.slave    bus
);
    typedef logic [WIDTH-1:0] val_t;

    localparam val_t ONE = val_t'(1);
    localparam val_t TWO = val_t'(2);

    val_t              cnt_q  [STAGES];
    val_t              emod   [STAGES];
    val_t              nxt    [STAGES];
    val_t              ld_val [STAGES];
    logic [STAGES-1:0] oor;
    logic [STAGES-1:0] term;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] carry;
    logic [STAGES-1:0] ld_bad;
    logic              err_q;
    logic [STAGES*WIDTH-1:0] cnt_flat;

    // Wrap is decoded before the +/-1, so the arithmetic never leaves WIDTH bits.
    always_comb begin : decode
        logic run;
        run = bus.EN;
        for (int i = 0; i < STAGES; i++) begin
            emod[i]   = (bus.Mode[i*WIDTH +: WIDTH] < TWO) ? ONE : bus.Mode[i*WIDTH +: WIDTH];
            oor[i]    = (cnt_q[i] >= emod[i]);
            term[i]   = !oor[i] && (cnt_q[i] == (bus.UP ? (emod[i] - ONE) : '0));
            adv[i]    = run;
            carry[i]  = run & term[i];
            run       = carry[i];
            ld_val[i] = bus.Data[i*WIDTH +: WIDTH];
            ld_bad[i] = (ld_val[i] >= emod[i]);
            nxt[i]    = cnt_q[i];
            if (oor[i]) begin
                nxt[i] = '0;
            end else if (adv[i]) begin
                if (term[i]) begin
                    nxt[i] = bus.UP ? '0 : (emod[i] - ONE);
                end else begin
                    nxt[i] = bus.UP ? (cnt_q[i] + ONE) : (cnt_q[i] - ONE);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!RST) begin
            for (int i = 0; i < STAGES; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else if (bus.LOAD) begin
            for (int i = 0; i < STAGES; i++) begin
                cnt_q[i] <= ld_bad[i] ? '0 : ld_val[i];
            end
            err_q <= |ld_bad;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                cnt_q[i] <= nxt[i];
            end
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < STAGES; i++) begin
            cnt_flat[i*WIDTH +: WIDTH] = cnt_q[i];
        end
    end

    assign bus.CNT   = cnt_flat;
    assign bus.Carry = carry;
    assign bus.Wrap  = carry[STAGES-1];
    assign bus.Err   = err_q;
endmodule

// File: tb/tb_modn_cascade_counter.sv
// tb/tb_modn_cascade_counter.sv - directed and randomized checks against a mixed-radix ripple model
module tb_modn_cascade_counter;
    localparam int S = 2;
    localparam int W = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    modn_cascade_counter_if #(.STAGES(S), .WIDTH(W)) bus();
    modn_cascade_counter #(.STAGES(S), .WIDTH(W)) dut (.Clk(clk), .RST(rst), .bus(bus));

    int ncmp = 0;
    int nfail = 0;
    int mv [S];
    int nx [S];
    int merr;
    logic [S-1:0] ecarry;
    logic last_wrap;
    logic [S*W-1:0] last_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int emod(input int i);
        int m;
        m = int'(bus.Mode[i*W +: W]);
        return (m < 2) ? 1 : m;
    endfunction

    function automatic logic [S*W-1:0] model_cnt();
        logic [S*W-1:0] p;
        p = '0;
        for (int i = 0; i < S; i++) p[i*W +: W] = W'(mv[i]);
        return p;
    endfunction

    // Add or subtract one from the mixed-radix number; a stage that wraps passes the step on.
    task automatic model_comb();
        logic run;
        int e;
        run = bus.EN;
        for (int i = 0; i < S; i++) begin
            e = emod(i);
            if (mv[i] >= e) begin
                nx[i] = 0;
                run = 1'b0;
            end else if (run) begin
                if (bus.UP ? (mv[i] == e - 1) : (mv[i] == 0)) begin
                    nx[i] = bus.UP ? 0 : e - 1;
                end else begin
                    nx[i] = bus.UP ? mv[i] + 1 : mv[i] - 1;
                    run = 1'b0;
                end
            end else begin
                nx[i] = mv[i];
            end
            ecarry[i] = run;
        end
    endtask

    task automatic cyc();
        int d;
        @(negedge clk);
        model_comb();
        check("cnt", bus.CNT, model_cnt());
        check("carry", bus.Carry, ecarry);
        check("wrap", bus.Wrap, ecarry[S-1]);
        check("err", bus.Err, merr);
        last_wrap = bus.Wrap;
        last_cnt  = bus.CNT;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < S; i++) mv[i] = 0;
            merr = 0;
        end else if (bus.LOAD) begin
            merr = 0;
            for (int i = 0; i < S; i++) begin
                d = int'(bus.Data[i*W +: W]);
                if (d < emod(i)) mv[i] = d;
                else begin
                    mv[i] = 0;
                    merr = 1;
                end
            end
        end else begin
            for (int i = 0; i < S; i++) mv[i] = nx[i];
        end
        #1;
    endtask

    initial begin
        int wraps;
        logic [S*W-1:0] wrap_cnt;
        logic [S*W-1:0] r;

        rst = 1'b0;
        bus.EN = 1'b1;
        bus.UP = 1'b1;
        bus.LOAD = 1'b0;
        bus.Data = '0;
        bus.Mode = {6'd60, 6'd60};
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < S; i++) mv[i] = 0;
        merr = 0;
        rst = 1'b1;
        check("reset_cnt", bus.CNT, 0);
        check("reset_err", bus.Err, 0);
        check("reset_carry_up", bus.Carry, 0);

        // Full 60x60 up-count: exactly one wrap, seen at {59,59}.
        wraps = 0;
        wrap_cnt = '0;
        for (int n = 0; n < 3600; n++) begin
            cyc();
            if (last_wrap) begin
                wraps++;
                wrap_cnt = last_cnt;
            end
        end
        check("wrap_count", wraps, 1);
        check("wrap_cnt", wrap_cnt, {6'd59, 6'd59});
        check("after_wrap", bus.CNT, 0);

        bus.LOAD = 1'b1;
        bus.Data = {6'd12, 6'd59};
        cyc();
        bus.LOAD = 1'b0;
        check("load_cnt", bus.CNT, {6'd12, 6'd59});
        check("load_err", bus.Err, 0);
        cyc();
        check("load_next", bus.CNT, {6'd13, 6'd0});

        bus.LOAD = 1'b1;
        bus.Data = {6'd5, 6'd61};
        cyc();
        bus.LOAD = 1'b0;
        check("bad_load_cnt", bus.CNT, {6'd5, 6'd0});
        check("bad_load_err", bus.Err, 1);
        repeat (5) cyc();
        check("err_sticky", bus.Err, 1);
        bus.LOAD = 1'b1;
        bus.Data = {6'd1, 6'd2};
        cyc();
        check("err_cleared", bus.Err, 0);

        bus.Data = '0;
        cyc();
        bus.LOAD = 1'b0;
        bus.UP = 1'b0;
        #1;
        check("down_carry", bus.Carry, 2'b11);
        check("down_wrap", bus.Wrap, 1);
        cyc();
        check("down_cnt", bus.CNT, {6'd59, 6'd59});
        bus.UP = 1'b1;
        cyc();
        check("up_again", bus.CNT, 0);

        bus.LOAD = 1'b1;
        bus.Data = {6'd7, 6'd45};
        cyc();
        bus.LOAD = 1'b0;
        check("load_45", bus.CNT, {6'd7, 6'd45});
        bus.Mode = {6'd60, 6'd24};
        bus.EN = 1'b0;
        #1;
        check("oor_no_carry", bus.Carry[0], 0);
        cyc();
        check("oor_fix", bus.CNT, {6'd7, 6'd0});
        bus.Mode = {6'd60, 6'd1};
        bus.EN = 1'b1;
        #1;
        check("mod1_carry", bus.Carry[0], 1);
        repeat (3) cyc();
        check("mod1_count", bus.CNT, {6'd10, 6'd0});

        bus.Mode = {6'd60, 6'd60};
        bus.LOAD = 1'b1;
        bus.Data = {6'd0, 6'd63};
        cyc();
        check("set_err", bus.Err, 1);
        rst = 1'b0;
        bus.Data = {6'd3, 6'd3};
        cyc();
        check("rst_over_load_cnt", bus.CNT, 0);
        check("rst_over_load_err", bus.Err, 0);
        rst = 1'b1;
        bus.LOAD = 1'b0;

        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(99) != 0);
            bus.LOAD = ($urandom_range(15) == 0);
            bus.EN = ($urandom_range(3) != 0);
            bus.UP = 1'($urandom_range(1));
            r = bus.Mode;
            for (int i = 0; i < S; i++) begin
                if ($urandom_range(31) == 0)
                    r[i*W +: W] = W'(($urandom_range(7) == 0) ? $urandom_range(63) : $urandom_range(12));
            end
            bus.Mode = r;
            for (int i = 0; i < S; i++) r[i*W +: W] = W'($urandom_range(15));
            bus.Data = r;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
